// File: rtl/bist_pkg.sv
// Shared types and constants for the 3-bit BIST test-pattern generator.
// Optional feature macro: TPG_ZERO_PATTERN_EN (inserts the all-zero pattern, period 8).
package bist_pkg;

    localparam int PAT_W = 3;

    // Feedback taps for x^3 + x^2 + 1: feedback bit is q[2] ^ q[1].
    localparam logic [PAT_W-1:0] TAP_MASK = 3'b110;

    localparam int MAX_PAT_LFSR = 7;
    localparam int MAX_PAT_ZERO = 8;

`ifdef TPG_ZERO_PATTERN_EN
    localparam int MAX_PAT = MAX_PAT_ZERO;
`else
    localparam int MAX_PAT = MAX_PAT_LFSR;
`endif

    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_t;

    function automatic logic lfsr_feedback(input logic [PAT_W-1:0] q);
        return ^(q & TAP_MASK);
    endfunction

endpackage

// File: rtl/tpg_lfsr.sv
// 3-bit Fibonacci LFSR with synchronous load and advance enable.
// With TPG_ZERO_PATTERN_EN the sequence is extended to visit 000 after 100.
module tpg_lfsr
    import bist_pkg::*;
#(
    parameter logic [PAT_W-1:0] SEED = 3'b001
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    output logic [PAT_W-1:0] q
);

    logic [PAT_W-1:0] q_reg;
    logic [PAT_W-1:0] q_next;
    logic [PAT_W-1:0] shift_next;

    assign shift_next[0] = lfsr_feedback(q_reg);

    for (genvar gi = 1; gi < PAT_W; gi++) begin : g_shift
        assign shift_next[gi] = q_reg[gi-1];
    end

    always_comb begin
        q_next = q_reg;
        if (load) begin
            q_next = SEED;
        end else if (en) begin
`ifdef TPG_ZERO_PATTERN_EN
            // Splice 000 between 100 and 001 so the all-zero vector is covered.
            if (q_reg == {1'b1, {(PAT_W-1){1'b0}}}) begin
                q_next = '0;
            end else if (q_reg == '0) begin
                q_next = {{(PAT_W-1){1'b0}}, 1'b1};
            end else begin
                q_next = shift_next;
            end
`else
            q_next = shift_next;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_reg <= SEED;
        end else begin
            q_reg <= q_next;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/bist_tpg.sv
// BIST test-pattern generator: run-control FSM, pattern counter and registered outputs.
// Optional feature macro: TPG_ZERO_PATTERN_EN (raises the N_PAT limit to 8).
module bist_tpg
    import bist_pkg::*;
#(
    parameter int               N_PAT = 7,
    parameter logic [PAT_W-1:0] SEED  = 3'b001
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic             abort,
    input  logic             stall,
    output logic [PAT_W-1:0] pat,
    output logic             pat_valid,
    output logic             misr_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pat_cnt
);

    if (N_PAT < 1 || N_PAT > MAX_PAT) begin : g_bad_n_pat
        $error("bist_tpg: N_PAT=%0d outside 1..%0d", N_PAT, MAX_PAT);
    end

    if (SEED == '0) begin : g_bad_seed
        $error("bist_tpg: SEED must be nonzero");
    end

    localparam logic [CNT_W-1:0] N_PAT_C = CNT_W'(N_PAT);

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] cnt_next;
    logic [PAT_W-1:0] lfsr_q;
    logic             lfsr_load;
    logic             lfsr_en;
    logic             issue;
    logic             kill;

    tpg_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk   (CLK),
        .rst_n (RST_N),
        .load  (lfsr_load),
        .en    (lfsr_en),
        .q     (lfsr_q)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = pat_cnt;
        lfsr_load  = 1'b0;
        lfsr_en    = 1'b0;
        issue      = 1'b0;
        kill       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start && !abort) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    kill       = 1'b1;
                    state_next = IDLE;
                end else begin
                    lfsr_load  = 1'b1;
                    cnt_next   = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    kill       = 1'b1;
                    state_next = IDLE;
                end else if (!stall) begin
                    issue    = 1'b1;
                    lfsr_en  = 1'b1;
                    cnt_next = pat_cnt + 1'b1;
                    if (cnt_next == N_PAT_C) begin
                        state_next = FLUSH;
                    end
                end
            end
            FLUSH: begin
                kill       = abort;
                state_next = abort ? IDLE : DONE;
            end
            DONE: begin
                kill       = abort;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are registered from next-state decisions so they line up with state_reg.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_reg <= IDLE;
            pat       <= '0;
            pat_valid <= 1'b0;
            misr_en   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pat_cnt   <= '0;
        end else begin
            state_reg <= state_next;
            pat_cnt   <= cnt_next;
            pat_valid <= issue;
            misr_en   <= pat_valid && !kill;
            busy      <= (state_next == LOAD) || (state_next == RUN) || (state_next == FLUSH);
            done      <= (state_next == DONE);
            if (issue) begin
                pat <= lfsr_q;
            end else if (state_next == IDLE) begin
                pat <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bist_tpg.sv
// Scoreboard bench for bist_tpg: stimulus queues expected patterns, monitors compare on negedge.
module tb_bist_tpg;

`ifdef TPG_ZERO_PATTERN_EN
    localparam int NP = 8;
`else
    localparam int NP = 7;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic       start = 1'b0, abort = 1'b0, stall = 1'b0;
    logic [2:0] pat;
    logic       pat_valid, misr_en, busy, done;
    logic [3:0] pat_cnt;

    logic       start1 = 1'b0;
    logic       abort1 = 1'b0, stall1 = 1'b0;
    logic [2:0] pat1;
    logic       pat_valid1, misr_en1, busy1, done1;
    logic [3:0] pat_cnt1;

    bist_tpg #(.N_PAT(NP), .SEED(3'b001)) u_dut (
        .CLK(clk), .RST_N(rst_n), .start(start), .abort(abort), .stall(stall),
        .pat(pat), .pat_valid(pat_valid), .misr_en(misr_en), .busy(busy),
        .done(done), .pat_cnt(pat_cnt)
    );

    bist_tpg #(.N_PAT(1), .SEED(3'b001)) u_one (
        .CLK(clk), .RST_N(rst_n), .start(start1), .abort(abort1), .stall(stall1),
        .pat(pat1), .pat_valid(pat_valid1), .misr_en(misr_en1), .busy(busy1),
        .done(done1), .pat_cnt(pat_cnt1)
    );

    int checks = 0;
    int fails  = 0;
    int valid_cnt = 0, done_cnt = 0, valid1_cnt = 0, done1_cnt = 0;
    logic [2:0] exp_q[$];
    logic [2:0] exp1_q[$];
    logic [2:0] seq[8] = '{3'b001, 3'b010, 3'b101, 3'b011, 3'b111, 3'b110, 3'b100, 3'b000};

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endfunction

    // Main-instance monitor: pattern scoreboard and misr_en delay model.
    logic prev_valid = 1'b0, prev_kill = 1'b1;
    always @(negedge clk) begin
        if (pat_valid) begin
            valid_cnt++;
            if (exp_q.size() == 0) check("unexpected_pat", {29'd0, pat}, 32'hFFFF);
            else check("pat", {29'd0, pat}, {29'd0, exp_q.pop_front()});
        end
        if (done) done_cnt++;
        check("misr_en", {31'd0, misr_en}, {31'd0, prev_valid && !prev_kill});
        prev_valid = pat_valid;
        prev_kill  = !rst_n || abort;
    end

    logic prev_valid1 = 1'b0, prev_kill1 = 1'b1;
    always @(negedge clk) begin
        if (pat_valid1) begin
            valid1_cnt++;
            if (exp1_q.size() == 0) check("unexpected_pat1", {29'd0, pat1}, 32'hFFFF);
            else check("pat1", {29'd0, pat1}, {29'd0, exp1_q.pop_front()});
        end
        if (done1) done1_cnt++;
        if (prev_valid1 || misr_en1)
            check("misr_en1", {31'd0, misr_en1}, {31'd0, prev_valid1 && !prev_kill1});
        prev_valid1 = pat_valid1;
        prev_kill1  = !rst_n;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input int base);
        int k;
        for (k = 0; k < 40; k++) begin
            tick(1);
            if (done_cnt > base) break;
        end
        if (k == 40) check("done_timeout", 0, 1);
    endtask

    task automatic wait_pat(input logic [2:0] target);
        int k;
        for (k = 0; k < 30; k++) begin
            tick(1);
            if (pat_valid && pat === target) break;
        end
        if (k == 30) check("pat_wait_timeout", 0, 1);
    endtask

    int base_v, base_d;

    initial begin
        tick(3);
        check("rst_pat", {29'd0, pat}, 0);
        check("rst_valid", {31'd0, pat_valid}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_cnt", {28'd0, pat_cnt}, 0);
        rst_n = 1'b1;
        tick(2);

        // Full run
        for (int i = 0; i < NP; i++) exp_q.push_back(seq[i]);
        base_v = valid_cnt; base_d = done_cnt;
        start = 1'b1; tick(1); start = 1'b0;
        check("load_busy", {31'd0, busy}, 1);
        check("load_valid", {31'd0, pat_valid}, 0);
        wait_done(base_d);
        check("run_cnt", {28'd0, pat_cnt}, NP);
        tick(3);
        check("run_valid_total", valid_cnt - base_v, NP);
        check("run_done_pulses", done_cnt - base_d, 1);
        check("run_idle_pat", {29'd0, pat}, 0);
        check("run_idle_busy", {31'd0, busy}, 0);
        check("run_cnt_kept", {28'd0, pat_cnt}, NP);

        // Stall after the 2nd pattern
        for (int i = 0; i < NP; i++) exp_q.push_back(seq[i]);
        base_v = valid_cnt; base_d = done_cnt;
        start = 1'b1; tick(1); start = 1'b0;
        wait_pat(3'b010);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("stall_pat_hold", {29'd0, pat}, 3'b010);
            check("stall_valid", {31'd0, pat_valid}, 0);
        end
        stall = 1'b0;
        wait_done(base_d);
        tick(2);
        check("stall_valid_total", valid_cnt - base_v, NP);
        check("stall_cnt", {28'd0, pat_cnt}, NP);
        check("stall_done_pulses", done_cnt - base_d, 1);

        // Abort on the 4th RUN cycle
        for (int i = 0; i < 3; i++) exp_q.push_back(seq[i]);
        base_d = done_cnt;
        start = 1'b1; tick(1); start = 1'b0;
        tick(1);
        tick(3);
        abort = 1'b1; tick(1); abort = 1'b0;
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_valid", {31'd0, pat_valid}, 0);
        check("abort_misr", {31'd0, misr_en}, 0);
        check("abort_cnt", {28'd0, pat_cnt}, 3);
        tick(5);
        check("abort_no_done", done_cnt - base_d, 0);
        check("abort_pat_idle", {29'd0, pat}, 0);

        // Reset mid-run
        for (int i = 0; i < 2; i++) exp_q.push_back(seq[i]);
        base_d = done_cnt;
        start = 1'b1; tick(1); start = 1'b0;
        tick(3);
        rst_n = 1'b0; tick(1);
        check("mrst_pat", {29'd0, pat}, 0);
        check("mrst_valid", {31'd0, pat_valid}, 0);
        check("mrst_misr", {31'd0, misr_en}, 0);
        check("mrst_busy", {31'd0, busy}, 0);
        check("mrst_cnt", {28'd0, pat_cnt}, 0);
        rst_n = 1'b1; tick(4);
        check("mrst_no_done", done_cnt - base_d, 0);
        check("mrst_idle_busy", {31'd0, busy}, 0);

        // start together with abort in IDLE
        base_v = valid_cnt;
        start = 1'b1; abort = 1'b1; tick(1); start = 1'b0; abort = 1'b0;
        check("sa_busy", {31'd0, busy}, 0);
        tick(3);
        check("sa_busy_later", {31'd0, busy}, 0);
        check("sa_no_valid", valid_cnt - base_v, 0);

        // Single-pattern instance
        exp1_q.push_back(3'b001);
        start1 = 1'b1; tick(1); start1 = 1'b0;
        for (int k = 0; k < 20 && done1_cnt == 0; k++) tick(1);
        tick(2);
        check("one_done_pulses", done1_cnt, 1);
        check("one_valid_total", valid1_cnt, 1);
        check("one_cnt", {28'd0, pat_cnt1}, 1);

        check("queue_empty", exp_q.size(), 0);
        check("queue1_empty", exp1_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bist_tpg.md
BIST_TPG -- requirements
Module: bist_tpg

Interface
REQ-001 Parameter N_PAT, default 7, number of patterns issued per run; legal 1..7, or 1..8 with TPG_ZERO_PATTERN_EN; any other value SHALL be an elaboration error.
REQ-002 Parameter SEED, default 3'b001, first pattern of every run; SHALL be nonzero.
REQ-003 CLK  input  1  sole clock; all state updates on posedge CLK.
REQ-004 RST_N  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  run request; sampled only in IDLE.
REQ-006 abort  input  1  terminate run; no done pulse.
REQ-007 stall  input  1  freeze pattern advance during RUN.
REQ-008 pat  output  3  test pattern; pat[0]/pat[1]/pat[2] drive MISR e0/e1/e2.
REQ-009 pat_valid  output  1  pat is a new pattern this cycle.
REQ-010 misr_en  output  1  pat_valid delayed one cycle; MISR capture enable matching 1-cycle CUT latency.
REQ-011 busy  output  1  high in LOAD, RUN, FLUSH.
REQ-012 done  output  1  one-cycle pulse at normal completion.
REQ-013 pat_cnt  output  4  patterns issued in current or last run.

Function
REQ-014 FSM states IDLE, LOAD, RUN, FLUSH, DONE; all outputs registered.
REQ-015 IDLE: start=1 & abort=0 -> LOAD; otherwise stay; start ignored outside IDLE.
REQ-016 LOAD: lfsr<=SEED, pat_cnt<=0 -> RUN; pat_valid=0.
REQ-017 RUN, stall=0: pat=lfsr, pat_valid=1, lfsr advances, pat_cnt+1; on the cycle pat_cnt reaches N_PAT -> FLUSH.
REQ-018 RUN, stall=1: pat held, pat_valid=0, lfsr and pat_cnt held, state held.
REQ-019 Next-state polynomial x^3+x^2+1: next = {q[1:0], q[2]^q[1]}; from 001 sequence 001,010,101,011,111,110,100, then wraps to 001.
REQ-020 FLUSH: pat_valid=0, misr_en still 1 (last pattern captured) -> DONE after 1 cycle.
REQ-021 DONE: done=1 for exactly one cycle, busy=0 -> IDLE; pat_cnt retains final value until next LOAD.
REQ-022 abort=1 in LOAD/RUN/FLUSH/DONE -> IDLE next cycle, pat_valid=0, misr_en=0 next cycle, no done; abort dominates start and stall.
REQ-023 pat in IDLE = 3'b000; pat holds last value during FLUSH/DONE.
REQ-024 pat_cnt never exceeds N_PAT; no pattern repeats within one run.

Reset
REQ-025 RST_N=0 at posedge CLK: state=IDLE, lfsr=SEED, pat=0, pat_valid=0, misr_en=0, busy=0, done=0, pat_cnt=0.
REQ-026 Reset mid-run SHALL override all inputs; no done pulse; first cycle after release is IDLE.

Configuration
REQ-027 Macro TPG_ZERO_PATTERN_EN defined: state 100 steps to 000, 000 steps to 001 (period 8, all-zero pattern covered), N_PAT max 8.
REQ-028 Macro undefined: pure maximal LFSR, period 7, 000 never issued during RUN, N_PAT max 7.

Structure
REQ-029 Package bist_pkg SHALL hold the state enum, PAT_W=3, the tap constant, and max-pattern constants for both configurations.
REQ-030 Sub-module tpg_lfsr SHALL hold the 3-bit register with load, enable, and next-state logic (including zero-insertion under the macro); bist_tpg holds the FSM and counters.

Verification
REQ-031 Defaults, start pulse in IDLE -> LOAD, then pat=001,010,101,011,111,110,100 with pat_valid=1 on 7 consecutive cycles, FLUSH, done pulse 1 cycle, pat_cnt=7.
REQ-032 stall=1 for 3 cycles after the 2nd pattern -> pat holds 010, pat_valid=0 for 3 cycles, sequence resumes at 101, total valid cycles = 7.
REQ-033 abort at the 4th RUN cycle -> IDLE next cycle, done never asserts, pat_cnt=3 (or 4 if that cycle's pattern issued), busy drops.
REQ-034 With TPG_ZERO_PATTERN_EN, N_PAT=8 -> 001,010,101,011,111,110,100,000, pat_cnt=8, done pulse.
REQ-035 RST_N=0 during RUN -> all outputs reach reset values next cycle; start together with abort in IDLE -> stays IDLE.
REQ-036 misr_en equals pat_valid delayed exactly one cycle in every scenario above, including N_PAT=1 (single pattern 001).
